// File: rtl/shift_reg_universal.sv
// shift_reg_universal: WIDTH-bit universal shift register with an 8-way opcode.
// Single-cycle ops (hold, invert, parallel load) complete at the start edge.
// Shift/rotate ops run amt 1-bit steps, one per enabled clock, under a
// start/busy/done handshake.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   load   update enable; 0 freezes register, counter, FSM and done
//   op     opcode, sampled with start
//   start  operation request, honoured in IDLE with load=1
//   amt    shift count, sampled with start (shift/rotate ops only)
//   i      parallel load data
//   sin_r  fill bit entering the MSB on logical shift right
//   sin_l  fill bit entering the LSB on shift left
//   o      register contents
//   busy   multi-cycle shift in progress
//   done   one-cycle completion pulse
//   sout   last bit shifted or rotated out
//   par    XOR-reduction of o (only when SHREG_PARITY_EN is defined)
//
// Optional feature macro: SHREG_PARITY_EN
module shift_reg_universal #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [2:0]       op,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] i,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] o,
    output logic             busy,
    output logic             done,
    output logic             sout
`ifdef SHREG_PARITY_EN
    ,
    output logic             par
`endif
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_INV  = 3'b001,
        OP_SHR  = 3'b010,
        OP_SHL  = 3'b011,
        OP_ROR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ASR  = 3'b110,
        OP_LOAD = 3'b111
    } op_t;

    localparam logic [AMT_W-1:0] CNT_ONE = {{(AMT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_o;
    logic             step_sout;

    // One 1-bit step of the latched shift/rotate op.
    always_comb begin
        step_o    = o_q;
        step_sout = sout_q;
        case (op_q)
            OP_SHR: begin
                step_o    = {sin_r, o_q[WIDTH-1:1]};
                step_sout = o_q[0];
            end
            OP_SHL: begin
                step_o    = {o_q[WIDTH-2:0], sin_l};
                step_sout = o_q[WIDTH-1];
            end
            OP_ROR: begin
                step_o    = {o_q[0], o_q[WIDTH-1:1]};
                step_sout = o_q[0];
            end
            OP_ROL: begin
                step_o    = {o_q[WIDTH-2:0], o_q[WIDTH-1]};
                step_sout = o_q[WIDTH-1];
            end
            OP_ASR: begin
                step_o    = {o_q[WIDTH-1], o_q[WIDTH-1:1]};
                step_sout = o_q[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        count_d = count_q;
        o_d     = o_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        if (load) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (op_t'(op))
                            OP_HOLD: done_d = 1'b1;
                            OP_INV: begin
                                o_d    = ~o_q;
                                done_d = 1'b1;
                            end
                            OP_LOAD: begin
                                o_d    = i;
                                done_d = 1'b1;
                            end
                            default: begin
                                if (amt == '0) begin
                                    done_d = 1'b1;
                                end else begin
                                    op_d    = op_t'(op);
                                    count_d = amt;
                                    state_d = SHIFT;
                                end
                            end
                        endcase
                    end
                end
                SHIFT: begin
                    o_d     = step_o;
                    sout_d  = step_sout;
                    count_d = count_q - CNT_ONE;
                    if (count_q == CNT_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= OP_HOLD;
            count_q <= '0;
            o_q     <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            count_q <= count_d;
            o_q     <= o_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign o    = o_q;
    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign sout = sout_q;

`ifdef SHREG_PARITY_EN
    assign par = ^o_q;
`endif

endmodule

// File: tb/tb_shift_reg_universal.sv
// Testbench for shift_reg_universal (WIDTH=8, AMT_W=4): table of operations
// with hand-derived expected results, plus sequences for stall, back-to-back
// start on done, and asynchronous reset mid-shift.
module tb_shift_reg_universal;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             load;
    logic [2:0]       op;
    logic             start;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] i;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] o;
    logic             busy;
    logic             done;
    logic             sout;
`ifdef SHREG_PARITY_EN
    logic             par;
`endif

    shift_reg_universal #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .op    (op),
        .start (start),
        .amt   (amt),
        .i     (i),
        .sin_r (sin_r),
        .sin_l (sin_l),
        .o     (o),
        .busy  (busy),
        .done  (done),
        .sout  (sout)
`ifdef SHREG_PARITY_EN
        ,
        .par   (par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] o;
        logic       sout;
        int         lat;     // enabled edges from start to done
        int         busy_n;  // cycles busy was seen high
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [3:0] amt;
        logic [7:0] i;
        logic       sr;
        logic       sl;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[13];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Continue from the negedge after some edge until done, then compare
    // against the oldest scoreboard entry.
    task automatic wait_done(input string tag, input int edges_in, input int busy_in);
        int   edges;
        int   busy_n;
        exp_t e;
        edges  = edges_in;
        busy_n = busy_in;
        while (!done && edges < 64) begin
            if (busy) busy_n++;
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        e = sb.pop_front();
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " o"}, 32'(o), 32'(e.o));
        check({tag, " sout"}, 32'(sout), 32'(e.sout));
        check({tag, " latency"}, 32'(edges), 32'(e.lat));
        check({tag, " busy cycles"}, 32'(busy_n), 32'(e.busy_n));
        check({tag, " busy at done"}, 32'(busy), 32'd0);
`ifdef SHREG_PARITY_EN
        check({tag, " par"}, 32'(par), 32'(^e.o));
`endif
    endtask

    task automatic run_op(input logic [2:0] p_op, input logic [3:0] p_amt,
                          input logic [7:0] p_i, input logic p_sr, input logic p_sl,
                          input exp_t e, input string tag);
        sb.push_back(e);
        op    = p_op;
        amt   = p_amt;
        i     = p_i;
        sin_r = p_sr;
        sin_l = p_sl;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(tag, 1, 0);
    endtask

    initial begin
        int edges;
        exp_t e;

        //          op      amt    i      sr    sl      o      sout lat busy
        vecs[0]  = '{3'b111, 4'd0,  8'hA5, 1'b0, 1'b0, '{8'hA5, 1'b0, 1,  0}};
        vecs[1]  = '{3'b010, 4'd3,  8'h00, 1'b0, 1'b0, '{8'h14, 1'b1, 4,  3}};
        vecs[2]  = '{3'b001, 4'd0,  8'h00, 1'b0, 1'b0, '{8'hEB, 1'b1, 1,  0}};
        vecs[3]  = '{3'b111, 4'd0,  8'h81, 1'b0, 1'b0, '{8'h81, 1'b1, 1,  0}};
        vecs[4]  = '{3'b101, 4'd1,  8'h00, 1'b0, 1'b0, '{8'h03, 1'b1, 2,  1}};
        vecs[5]  = '{3'b111, 4'd0,  8'h90, 1'b0, 1'b0, '{8'h90, 1'b1, 1,  0}};
        vecs[6]  = '{3'b110, 4'd2,  8'h00, 1'b0, 1'b0, '{8'hE4, 1'b0, 3,  2}};
        vecs[7]  = '{3'b011, 4'd0,  8'h00, 1'b0, 1'b1, '{8'hE4, 1'b0, 1,  0}};
        vecs[8]  = '{3'b011, 4'd12, 8'h00, 1'b0, 1'b1, '{8'hFF, 1'b1, 13, 12}};
        vecs[9]  = '{3'b000, 4'd0,  8'h5A, 1'b0, 1'b0, '{8'hFF, 1'b1, 1,  0}};
        vecs[10] = '{3'b111, 4'd0,  8'h07, 1'b0, 1'b0, '{8'h07, 1'b1, 1,  0}};
        vecs[11] = '{3'b100, 4'd12, 8'h00, 1'b0, 1'b0, '{8'h70, 1'b0, 13, 12}};
        vecs[12] = '{3'b010, 4'd15, 8'h00, 1'b1, 1'b0, '{8'hFF, 1'b1, 16, 15}};

        reset = 1'b0;
        load  = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        amt   = '0;
        i     = '0;
        sin_r = 1'b0;
        sin_l = 1'b0;
        repeat (2) @(negedge clk);
        check("reset o", 32'(o), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sout", 32'(sout), 32'd0);
`ifdef SHREG_PARITY_EN
        check("reset par", 32'(par), 32'd0);
`endif
        reset = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 13; k++) begin
            run_op(vecs[k].op, vecs[k].amt, vecs[k].i, vecs[k].sr, vecs[k].sl,
                   vecs[k].e, $sformatf("vec%0d", k));
        end

        // Stall: shift right by 5 from A5, load low for 3 cycles mid-shift,
        // with a start held during busy that must be ignored.
        e = '{8'hA5, 1'b1, 1, 0};
        run_op(3'b111, 4'd0, 8'hA5, 1'b0, 1'b0, e, "stall load");
        sb.push_back('{8'h05, 1'b0, 9, 8});
        op    = 3'b010;
        amt   = 4'd5;
        sin_r = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        check("stall busy after start", 32'(busy), 32'd1);
        check("stall o at start edge", 32'(o), 32'h0A5);
        @(posedge clk);
        @(negedge clk);
        edges++;
        check("stall o step1", 32'(o), 32'h052);
        load  = 1'b0;
        start = 1'b1;
        op    = 3'b111;
        i     = 8'h00;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
            check("stall o frozen", 32'(o), 32'h052);
            check("stall busy frozen", 32'(busy), 32'd1);
            check("stall done low", 32'(done), 32'd0);
        end
        load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        edges++;
        start = 1'b0;
        check("stall o step2", 32'(o), 32'h029);
        wait_done("stall shift", edges, 5);
        @(posedge clk);
        @(negedge clk);
        check("stall no queued start o", 32'(o), 32'h005);
        check("stall no queued busy", 32'(busy), 32'd0);
        check("stall done one cycle", 32'(done), 32'd0);

        // Start in the same cycle as done is accepted.
        op    = 3'b111;
        i     = 8'h11;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("b2b first done", 32'(done), 32'd1);
        check("b2b first o", 32'(o), 32'h011);
        i = 8'h22;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b second done", 32'(done), 32'd1);
        check("b2b second o", 32'(o), 32'h022);
        @(posedge clk);
        @(negedge clk);
        check("b2b done drops", 32'(done), 32'd0);

        // Asynchronous reset between edges in the middle of a shift.
        e = '{8'hC3, 1'b0, 1, 0};
        run_op(3'b111, 4'd0, 8'hC3, 1'b0, 1'b0, e, "rst load");
        op    = 3'b011;
        amt   = 4'd6;
        sin_l = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst pre o", 32'(o), 32'h00C);
        check("rst pre sout", 32'(sout), 32'd1);
        check("rst pre busy", 32'(busy), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("rst async o", 32'(o), 32'd0);
        check("rst async busy", 32'(busy), 32'd0);
        check("rst async done", 32'(done), 32'd0);
        check("rst async sout", 32'(sout), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        e = '{8'h3C, 1'b0, 1, 0};
        run_op(3'b111, 4'd0, 8'h3C, 1'b0, 1'b0, e, "post rst load");
        e = '{8'h0F, 1'b0, 3, 2};
        run_op(3'b010, 4'd2, 8'h00, 1'b0, 1'b0, e, "post rst shr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_universal.md
Name: shift_reg_universal

Overview:
- Parametrised successor to the 4-bit mode-select shift register: WIDTH-bit universal register with an 8-way opcode.
- Adds multi-position shifts executed one bit per cycle under a start/busy/done handshake, serial fill inputs, and a serial-out bit.
- Sits in the datapath wherever a serialiser, bit-manipulation register or shift-by-N unit is needed.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- AMT_W, 4, width of the shift-amount input; amounts 0..2^AMT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  update enable: when 0 the whole block freezes (register, counter, FSM, done).
- op  in  3  operation code, sampled with start.
- start  in  1  operation request, honoured only in IDLE with load=1.
- amt  in  AMT_W  shift count, sampled with start; used by shift/rotate ops only.
- i  in  WIDTH  parallel load data (op 111).
- sin_r  in  1  fill bit entering the MSB on logical shift right.
- sin_l  in  1  fill bit entering the LSB on shift left.
- o  out  WIDTH  register contents.
- busy  out  1  high while a multi-cycle shift is in progress.
- done  out  1  one-cycle completion pulse.
- sout  out  1  last bit shifted or rotated out.

Behaviour:
- Reset (reset=0, asynchronous): o=0, busy=0, done=0, sout=0, count=0, FSM=IDLE. Takes effect immediately, including mid-shift. No partial result is kept.
- Opcodes:
  - 000 hold.
  - 001 invert (o <= ~o).
  - 010 logical shift right: o[k] <= o[k+1], MSB <= sin_r, sout <= o[0].
  - 011 shift left: o[k] <= o[k-1], LSB <= sin_l, sout <= o[WIDTH-1].
  - 100 rotate right.
  - 101 rotate left.
  - 110 arithmetic shift right: MSB replicated.
  - 111 parallel load (o <= i).
- Rotates update sout with the bit that wraps.
- FSM states: IDLE, SHIFT. All transitions require load=1; with load=0, state, count, o and sout hold and done is 0.
- IDLE, start=1, op in {000,001,111}: o is updated at that edge, done=1 for the next cycle, stay in IDLE. busy never asserts.
- IDLE, start=1, shift/rotate op, amt=0: o unchanged, done=1 next cycle, stay in IDLE.
- IDLE, start=1, shift/rotate op, amt=N>0: latch op and count=N, busy=1, go to SHIFT. o is not changed at this edge.
- SHIFT: each enabled edge performs one 1-bit step and decrements count. On the edge where count goes 1->0, go to IDLE with busy=0 and done=1 for one cycle.
- Latency: N+1 enabled edges from start to done.
- amt >= WIDTH is legal and runs exactly N steps. Logical shifts end in all fill bits; rotates wrap modulo WIDTH.
- start while busy=1 is ignored and never queued. op/amt changes during SHIFT have no effect.
- done is registered and high for exactly one cycle. A start in the same cycle as done is accepted, because the FSM is already in IDLE.

Optional Feature:
- Macro: SHREG_PARITY_EN.
- Defined: extra output port par (1 bit) = XOR-reduction of o, combinational from the register; 0 after reset.
- Not defined: port par is absent and there is no parity logic. All other behaviour is identical.

Test Plan (WIDTH=8, AMT_W=4):
- op=111, i=8'hA5, start for 1 cycle -> o=8'hA5 after the edge; done=1 for 1 cycle; busy stays 0.
- o=8'hA5, op=010, amt=3, sin_r=0, start -> busy high for 3 cycles; after 4 edges o=8'h14, sout=1, done pulse; then op=001 -> o=8'hEB.
- o=8'h81, op=101, amt=1 -> o=8'h03, sout=1. Then op=110 from o=8'h90, amt=2 -> o=8'hE4, sout=0.
- Start a shift with amt=5, drop load for 3 cycles mid-shift -> o, count and busy frozen; done arrives 3 cycles later than unstalled; a second start while busy is ignored.
- op=011, amt=0 -> o unchanged, done pulse next cycle, busy never high. op=011, amt=12, sin_l=1 -> o=8'hFF after 13 edges.
- Assert reset low asynchronously mid-shift (between clock edges) -> o=0, busy=0, done=0, sout=0 immediately. After release, a new start works normally. With SHREG_PARITY_EN, par tracks ^o (8'h14 -> 0, 8'h03 -> 0, 8'h07 -> 1).
